// File: rtl/dcache_ctrl.sv
// dcache_ctrl: single-outstanding load/store controller for a 32-entry direct-mapped write-through data cache.
// Optional hit/miss/store counters are enabled with the DCACHE_STATS_EN macro.
module dcache_ctrl #(
  parameter int MEM_TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_is_store,
  input  logic [15:0]          req_addr,
  input  logic [63:0]          req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [63:0]          resp_data,
  output logic [4:0]           cache_rd_idx,
  output logic [7:0]           cache_rd_tag,
  input  logic [63:0]          cache_rd_data,
  input  logic                 cache_rd_valid,
  output logic                 cache_wr_en,
  output logic [4:0]           cache_wr_idx,
  output logic [7:0]           cache_wr_tag,
  output logic [63:0]          cache_wr_data,
  output logic [1:0]           mem_cmd,
  output logic [15:0]          mem_addr,
  output logic [63:0]          mem_wdata,
  input  logic [MEM_TAG_W-1:0] mem_resp,
  input  logic [63:0]          mem_data,
  input  logic [MEM_TAG_W-1:0] mem_tag
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [31:0]          stat_stores
`endif
);
  localparam logic [2:0] IDLE = 3'd0, HIT_RSP = 3'd1, LD_REQ = 3'd2, LD_WAIT = 3'd3, FILL = 3'd4, ST_REQ = 3'd5;
  logic [2:0] state_q, state_d;
  logic [12:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d, data_q, data_d;
  logic [MEM_TAG_W-1:0] txn_q, txn_d;
  logic idle, hs, fill, ld_req, st_req, unused_ok;
  assign idle = state_q == IDLE;
  assign fill = state_q == FILL;
  assign ld_req = state_q == LD_REQ;
  assign st_req = state_q == ST_REQ;
  assign hs = req_valid && idle;
  assign unused_ok = ^req_addr[2:0];
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    txn_d = txn_q;
    if (hs) begin
      addr_d = req_addr[15:3];
      wdata_d = req_wdata;
      data_d = cache_rd_data;
      state_d = req_is_store ? ST_REQ : cache_rd_valid ? HIT_RSP : LD_REQ;
    end
    if (state_q == HIT_RSP) state_d = IDLE;
    if (ld_req && mem_resp != '0) begin
      txn_d = mem_resp;
      state_d = LD_WAIT;
    end
    // A zero saved tag never matches, so stale responses after reset are dropped.
    if (state_q == LD_WAIT && txn_q != '0 && mem_tag == txn_q) begin
      data_d = mem_data;
      state_d = FILL;
    end
    if (fill) begin
      txn_d = '0;
      state_d = IDLE;
    end
    if (st_req && mem_resp != '0) state_d = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      txn_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      txn_q <= txn_d;
    end
  end
  assign req_ready = idle;
  assign resp_valid = state_q == HIT_RSP || fill || (st_req && mem_resp != '0);
  assign resp_data = (state_q == HIT_RSP || fill) ? data_q : '0;
  assign cache_rd_idx = idle ? req_addr[7:3] : addr_q[4:0];
  assign cache_rd_tag = idle ? req_addr[15:8] : addr_q[12:5];
  assign cache_wr_en = (hs && req_is_store && cache_rd_valid) || fill;
  assign cache_wr_idx = cache_rd_idx;
  assign cache_wr_tag = cache_rd_tag;
  assign cache_wr_data = fill ? data_q : req_wdata;
  assign mem_cmd = ld_req ? 2'd1 : st_req ? 2'd2 : 2'd0;
  assign mem_addr = (ld_req || st_req) ? {addr_q, 3'b000} : '0;
  assign mem_wdata = st_req ? wdata_q : '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, stores_q, stores_d;
  always_comb begin
    hits_d = (hs && !req_is_store && cache_rd_valid && ~&hits_q) ? hits_q + 32'd1 : hits_q;
    misses_d = (hs && !req_is_store && !cache_rd_valid && ~&misses_q) ? misses_q + 32'd1 : misses_q;
    stores_d = (hs && req_is_store && ~&stores_q) ? stores_q + 32'd1 : stores_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q <= '0;
      misses_q <= '0;
      stores_q <= '0;
    end else begin
      hits_q <= hits_d;
      misses_q <= misses_d;
      stores_q <= stores_d;
    end
  end
  assign stat_hits = hits_q;
  assign stat_misses = misses_q;
  assign stat_stores = stores_q;
`endif
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller in front of the 32-entry direct-mapped data cache array (5-bit index, 8-bit tag, 64-bit lines, 1 read port, 1 write port).
- Accepts one load or store at a time from the LSQ and performs the cache lookup.
- On a load miss, issues a tagged memory request, waits for the tagged response, fills the cache and returns the data.
- Stores are write-through with no write-allocate.

Parameters:
- MEM_TAG_W, 4, width of memory transaction tag; tag 0 means "no transaction".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  LSQ request present
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  16  byte address; [15:8] tag, [7:3] index, [2:0] ignored (doubleword aligned)
- req_wdata  in  64  store data
- req_ready  out  1  controller can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: request completed
- resp_data  out  64  load data (0 for stores)
- cache_rd_idx  out  5  index to cache read port
- cache_rd_tag  out  8  tag to cache read port
- cache_rd_data  in  64  cache read data
- cache_rd_valid  in  1  cache hit indication
- cache_wr_en  out  1  cache write enable
- cache_wr_idx  out  5  cache write index
- cache_wr_tag  out  8  cache write tag
- cache_wr_data  out  64  cache write data
- mem_cmd  out  2  0 = NONE, 1 = LOAD, 2 = STORE
- mem_addr  out  16  memory address, [2:0] forced to 0
- mem_wdata  out  64  memory store data
- mem_resp  in  MEM_TAG_W  nonzero = command accepted, value is transaction tag
- mem_data  in  64  memory return data
- mem_tag  in  MEM_TAG_W  tag of data on mem_data; 0 = none

Behaviour:
Interface:
- Reset: reset is synchronous, active-high; clock is clock.
- Reset values: all outputs 0 except req_ready = 1; state IDLE; saved tag 0.

States: IDLE, HIT_RSP, LD_REQ, LD_WAIT, FILL, ST_REQ.

Request capture and lookup:
- req_ready = 1 only in IDLE.
- Handshake is req_valid && req_ready. On handshake, latch addr, wdata and is_store.
- cache_rd_idx/cache_rd_tag are driven combinationally from req_addr in IDLE, and from the latched address otherwise.

IDLE, on load handshake:
- Hit: latch cache_rd_data → HIT_RSP.
- Miss → LD_REQ.

IDLE, on store handshake:
- If hit: cache_wr_en = 1 the same cycle with idx/tag/wdata (update in place).
- Always → ST_REQ.

HIT_RSP:
- resp_valid = 1, resp_data = latched data → IDLE.
- Load-hit latency: 1 cycle after handshake.

LD_REQ:
- mem_cmd = LOAD, mem_addr = latched line address.
- mem_resp == 0: stay, reissue next cycle.
- mem_resp != 0: save it as txn tag → LD_WAIT.

LD_WAIT:
- mem_cmd = NONE.
- When mem_tag == saved tag (nonzero): latch mem_data → FILL.
- Other tags are ignored.

FILL:
- cache_wr_en = 1 with latched idx/tag/data.
- resp_valid = 1, resp_data = fill data.
- Clear saved tag → IDLE.
- A new request cannot be accepted in FILL, so read-after-fill sees the new line.

ST_REQ:
- mem_cmd = STORE, mem_addr/mem_wdata from latch.
- mem_resp != 0: resp_valid = 1, resp_data = 0 → IDLE.
- mem_resp == 0: stay.
- No cache write on a store miss.

Boundaries:
- Only one outstanding transaction.
- A store hit and a later load to the same line: the load hits with the new data.
- Reset in any state: return to IDLE, clear saved tag, no resp_valid. Data arriving with a stale tag afterwards is ignored because a zero saved tag never matches.
- mem_tag == 0 never matches.
- Address bits [2:0] are ignored everywhere.

Outputs when not active:
- cache_wr_en = 0 except in the cycles stated above.
- mem_cmd = NONE except in LD_REQ and ST_REQ.

Optional Feature:
DCACHE_STATS_EN:
- Adds outputs stat_hits, stat_misses, stat_stores (32 bits each, reset 0, saturating at all-ones).
- stat_hits increments on load-hit handshake; stat_misses on load-miss handshake; stat_stores on store handshake.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Load miss with immediate accept:
   - After reset, load 0x1238.
   - mem_resp = 3 in LD_REQ; mem_tag = 3, mem_data = 0xDEAD_BEEF_0000_0001 two cycles later.
   - Expect cache_wr_en with idx = 7, tag = 0x12 in FILL, and resp_valid with that data.
   - A following load to 0x123F hits; resp 1 cycle after handshake.
2. Load miss with memory stalls:
   - mem_resp = 0 for 3 cycles, then 5.
   - Expect mem_cmd = LOAD held for 4 cycles.
   - mem_tag = 2 arriving first is ignored; completion only on mem_tag = 5.
3. Store hit:
   - Line 0x1238 resident; store 0x1238 with data 0xAAAA.
   - Expect cache_wr_en in the handshake cycle, then mem_cmd = STORE.
   - After mem_resp = 1, resp_valid with resp_data = 0.
   - Next load to 0x1238 returns 0xAAAA.
4. Store miss:
   - Store 0x4440.
   - Expect no cache_wr_en and a memory store.
   - Next load to 0x4440 misses.
5. Reset mid-miss:
   - Assert reset in LD_WAIT (saved tag 4); deassert; then drive mem_tag = 4.
   - Expect no resp_valid, no cache_wr_en, and req_ready = 1.
6. Back-pressure:
   - Hold req_valid during a miss.
   - Expect req_ready = 0 until the cycle after FILL; the second request is accepted exactly once.
